// File: rtl/matmul_mem_arbiter.sv
// Host/engine arbiter for one single-port matrix memory bank, with a bounded burst length per grant.
// Optional ARB_HOST_PRIO_EN: the host wins ties and is never preempted by the burst limit.
module matmul_mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  h_req,
    input  logic                  e_req,
    input  logic                  h_rd,
    input  logic                  e_rd,
    input  logic                  h_wr,
    input  logic                  e_wr,
    input  logic [ADDR_W-1:0]     h_row,
    input  logic [ADDR_W-1:0]     e_row,
    input  logic [ADDR_W-1:0]     h_col,
    input  logic [ADDR_W-1:0]     e_col,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    input  logic [DATA_WIDTH-1:0] e_wdata,
    output logic                  h_gnt,
    output logic                  e_gnt,
    output logic                  h_rvalid,
    output logic                  e_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_W-1:0]     mem_row,
    output logic [ADDR_W-1:0]     mem_col,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // state | meaning
    // IDLE  | no owner, memory enables held low
    // OWN_H | host owns the memory port
    // OWN_E | engine owns the memory port

    localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

`ifdef ARB_HOST_PRIO_EN
    localparam logic HOST_PRIO = 1'b1;
`else
    localparam logic HOST_PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, OWN_H, OWN_E} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] burst_cnt;
    logic             rr_last_e;
    logic             own_rd;
    logic             own_wr;
    logic             access;
    logic             limit_hit;

    always_comb begin
        own_rd    = 1'b0;
        own_wr    = 1'b0;
        mem_row   = '0;
        mem_col   = '0;
        mem_wdata = '0;
        case (state)
            OWN_H: begin
                own_rd    = h_rd;
                own_wr    = h_wr;
                mem_row   = h_row;
                mem_col   = h_col;
                mem_wdata = h_wdata;
            end
            OWN_E: begin
                own_rd    = e_rd;
                own_wr    = e_wr;
                mem_row   = e_row;
                mem_col   = e_col;
                mem_wdata = e_wdata;
            end
            default: ;
        endcase
        // A simultaneous rd+wr performs only the write.
        mem_wr_en = own_wr;
        mem_rd_en = own_rd & ~own_wr;
        access    = own_rd | own_wr;
        limit_hit = access && (burst_cnt == CNT_LAST);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (h_req && e_req)
                    state_nxt = (HOST_PRIO || rr_last_e) ? OWN_H : OWN_E;
                else if (h_req)
                    state_nxt = OWN_H;
                else if (e_req)
                    state_nxt = OWN_E;
            end
            OWN_H: begin
                if (!h_req)
                    state_nxt = e_req ? OWN_E : IDLE;
                else if (limit_hit && e_req && !HOST_PRIO)
                    state_nxt = OWN_E;
            end
            OWN_E: begin
                if (!e_req)
                    state_nxt = h_req ? OWN_H : IDLE;
                else if (limit_hit && h_req)
                    state_nxt = OWN_H;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            h_gnt     <= 1'b0;
            e_gnt     <= 1'b0;
            burst_cnt <= '0;
            rr_last_e <= 1'b1;
            h_rvalid  <= 1'b0;
            e_rvalid  <= 1'b0;
        end else begin
            state <= state_nxt;
            h_gnt <= (state_nxt == OWN_H);
            e_gnt <= (state_nxt == OWN_E);
            if (state_nxt != state) begin
                burst_cnt <= '0;
                if (state_nxt != IDLE)
                    rr_last_e <= (state_nxt == OWN_E);
            end else if (access && (burst_cnt != CNT_LAST)) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
            // Read return is tagged with the issuer, so it survives a grant handover.
            h_rvalid <= mem_rd_en && (state == OWN_H);
            e_rvalid <= mem_rd_en && (state == OWN_E);
        end
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_matmul_mem_arbiter.sv
// Bench for matmul_mem_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_matmul_mem_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int MB = 16;

    logic          clk;
    logic          reset_n;
    logic          h_req, e_req, h_rd, e_rd, h_wr, e_wr;
    logic [AW-1:0] h_row, e_row, h_col, e_col;
    logic [DW-1:0] h_wdata, e_wdata;
    logic          h_gnt, e_gnt, h_rvalid, e_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_row, mem_col;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [0:255];
    logic          mem_clear;

    int checks = 0;
    int errors = 0;

    matmul_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_W(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset_n(reset_n),
        .h_req(h_req), .e_req(e_req), .h_rd(h_rd), .e_rd(e_rd), .h_wr(h_wr), .e_wr(e_wr),
        .h_row(h_row), .e_row(e_row), .h_col(h_col), .e_col(e_col),
        .h_wdata(h_wdata), .e_wdata(e_wdata),
        .h_gnt(h_gnt), .e_gnt(e_gnt), .h_rvalid(h_rvalid), .e_rvalid(e_rvalid),
        .rdata(rdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_row(mem_row), .mem_col(mem_col), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_wr_en) begin
            mem[{mem_row, mem_col}] <= mem_wdata;
        end
        if (mem_rd_en) mem_rdata <= mem[{mem_row, mem_col}];
    end

    task automatic clear_inputs();
        h_req = 0; e_req = 0; h_rd = 0; e_rd = 0; h_wr = 0; e_wr = 0;
        h_row = '0; e_row = '0; h_col = '0; e_col = '0; h_wdata = '0; e_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        mem_clear = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({h_gnt, e_gnt, h_rvalid, e_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: gnt/rvalid=%b required 0000", {h_gnt, e_gnt, h_rvalid, e_rvalid});
        end
        checks++;
        if ({mem_rd_en, mem_wr_en, mem_row, mem_col, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mem: rd=%b wr=%b row=%0h col=%0h wd=%0h required all 0",
                     mem_rd_en, mem_wr_en, mem_row, mem_col, mem_wdata);
        end
        mem_clear = 0;
        reset_n = 1;
    endtask

    task automatic test_host_write_read();
        h_req = 1;
        #1;
        checks++;
        if (h_gnt !== 1'b0) begin
            errors++;
            $display("FAIL hwr_gnt_early: h_gnt=%b required 0", h_gnt);
        end
        @(negedge clk);
        checks++;
        if ({h_gnt, e_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL hwr_gnt: h_gnt/e_gnt=%b required 10", {h_gnt, e_gnt});
        end
        h_wr = 1; h_row = 2; h_col = 3; h_wdata = 8'hA5;
        #1;
        checks++;
        if ({mem_wr_en, mem_rd_en, mem_row, mem_col, mem_wdata} !== {1'b1, 1'b0, 4'd2, 4'd3, 8'hA5}) begin
            errors++;
            $display("FAIL hwr_write: wr=%b rd=%b row=%0d col=%0d wd=%0h required 1 0 2 3 a5",
                     mem_wr_en, mem_rd_en, mem_row, mem_col, mem_wdata);
        end
        @(negedge clk);
        h_wr = 0; h_rd = 1;
        #1;
        checks++;
        if (mem_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL hwr_rd_en: mem_rd_en=%b required 1", mem_rd_en);
        end
        @(negedge clk);
        h_rd = 0;
        #1;
        checks++;
        if ({h_rvalid, e_rvalid, rdata} !== {1'b1, 1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL hwr_readback: h_rv=%b e_rv=%b rdata=%0h required 1 0 a5", h_rvalid, e_rvalid, rdata);
        end
        @(negedge clk);
        h_req = 0;
        #1;
        checks++;
        if (h_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL hwr_rvalid_once: h_rvalid=%b required 0", h_rvalid);
        end
        @(negedge clk);
        checks++;
        if ({h_gnt, e_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL hwr_release: gnt=%b required 00", {h_gnt, e_gnt});
        end
    endtask

    task automatic test_tie_handover();
        do_reset();
        h_req = 1; e_req = 1;
        @(negedge clk);
        checks++;
        if ({h_gnt, e_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL tie_host_first: gnt=%b required 10", {h_gnt, e_gnt});
        end
        h_req = 0;
        @(negedge clk);
        checks++;
        if ({h_gnt, e_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL tie_handover: gnt=%b required 01", {h_gnt, e_gnt});
        end
        e_req = 0;
        @(negedge clk);
        checks++;
        if ({h_gnt, e_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL tie_idle: gnt=%b required 00", {h_gnt, e_gnt});
        end
    endtask

    task automatic test_burst_limit();
        int bad_gnt = 0;
        int bad_rv = 0;
        do_reset();
        e_req = 1;
        for (int i = 0; i < MB; i++) begin
            @(negedge clk);
            e_rd = 1; e_row = 5; e_col = AW'(i);
            if (i == 0) h_req = 1;
            #1;
            if ({h_gnt, e_gnt} !== 2'b01) bad_gnt++;
            if (i > 0 && e_rvalid !== 1'b1) bad_rv++;
        end
        checks++;
        if (bad_gnt != 0) begin
            errors++;
            $display("FAIL burst_hold: %0d cycles without engine grant, required 0", bad_gnt);
        end
        checks++;
        if (bad_rv != 0) begin
            errors++;
            $display("FAIL burst_rvalid_stream: %0d missing e_rvalid, required 0", bad_rv);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({h_gnt, e_gnt, e_rvalid, mem_rd_en} !== 4'b1010) begin
            errors++;
            $display("FAIL burst_switch: h_gnt e_gnt e_rv rd_en=%b required 1010",
                     {h_gnt, e_gnt, e_rvalid, mem_rd_en});
        end
        e_rd = 0;
        @(negedge clk);
        #1;
        checks++;
        if (e_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL burst_ignored_read: e_rvalid=%b required 0", e_rvalid);
        end
    endtask

    task automatic test_nonowner_write();
        h_wr = 1; h_row = 1; h_col = 1; h_wdata = 8'h11;
        #1;
        checks++;
        if (mem_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL nonown_setup_wr: mem_wr_en=%b required 1", mem_wr_en);
        end
        @(negedge clk);
        h_wr = 0;
        e_wr = 1; e_row = 1; e_col = 1; e_wdata = 8'h3C;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL nonown_wr_blocked: mem_wr_en=%b required 0", mem_wr_en);
        end
        @(negedge clk);
        e_wr = 0; h_rd = 1;
        @(negedge clk);
        h_rd = 0;
        #1;
        checks++;
        if ({h_rvalid, e_rvalid, rdata} !== {1'b1, 1'b0, 8'h11}) begin
            errors++;
            $display("FAIL nonown_readback: h_rv=%b e_rv=%b rdata=%0h required 1 0 11", h_rvalid, e_rvalid, rdata);
        end
    endtask

    task automatic test_rd_wr_same();
        @(negedge clk);
        h_rd = 1; h_wr = 1; h_row = 4; h_col = 4; h_wdata = 8'h77;
        #1;
        checks++;
        if ({mem_wr_en, mem_rd_en} !== 2'b10) begin
            errors++;
            $display("FAIL rdwr_enables: wr/rd=%b required 10", {mem_wr_en, mem_rd_en});
        end
        @(negedge clk);
        h_wr = 0;
        #1;
        checks++;
        if ({h_rvalid, e_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rdwr_no_rvalid: rvalid=%b required 00", {h_rvalid, e_rvalid});
        end
        @(negedge clk);
        h_rd = 0;
        #1;
        checks++;
        if ({h_rvalid, rdata} !== {1'b1, 8'h77}) begin
            errors++;
            $display("FAIL rdwr_readback: h_rv=%b rdata=%0h required 1 77", h_rvalid, rdata);
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        h_rd = 1; h_row = 4; h_col = 4;
        @(posedge clk);
        #2;
        reset_n = 0;
        #1;
        checks++;
        if ({h_gnt, e_gnt, h_rvalid, e_rvalid, mem_rd_en, mem_wr_en} !== 6'b000000) begin
            errors++;
            $display("FAIL midreset_clear: gnt rv en=%b required 000000",
                     {h_gnt, e_gnt, h_rvalid, e_rvalid, mem_rd_en, mem_wr_en});
        end
        @(negedge clk);
        h_rd = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        #1;
        checks++;
        if ({h_gnt, e_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_tie: gnt=%b required 10", {h_gnt, e_gnt});
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int m_owner, m_tenure, m_last, nxt;
        bit m_ph, m_pe, hp, o_rd, o_wr, acc, hit, oth_req, own_req;
        logic [AW-1:0] o_row, o_col;
        logic [DW-1:0] o_wd, m_pdata;
        logic [DW-1:0] ref_mem [0:255];
        int bad = 0;
`ifdef ARB_HOST_PRIO_EN
        hp = 1;
`else
        hp = 0;
`endif
        do_reset();
        mem_clear = 1;
        @(negedge clk);
        mem_clear = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        m_owner = 0; m_tenure = 0; m_last = 2; m_ph = 0; m_pe = 0; m_pdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            h_req = h_req ? ($urandom_range(0, 31) != 0) : ($urandom_range(0, 3) == 0);
            e_req = e_req ? ($urandom_range(0, 31) != 0) : ($urandom_range(0, 3) == 0);
            h_rd = ($urandom_range(0, 1) == 0); h_wr = ($urandom_range(0, 3) == 0);
            e_rd = ($urandom_range(0, 1) == 0); e_wr = ($urandom_range(0, 3) == 0);
            h_row = AW'($urandom_range(0, 3)); h_col = AW'($urandom_range(0, 3));
            e_row = AW'($urandom_range(0, 3)); e_col = AW'($urandom_range(0, 3));
            h_wdata = DW'($urandom); e_wdata = DW'($urandom);
            #1;
            o_rd = 0; o_wr = 0; o_row = '0; o_col = '0; o_wd = '0;
            if (m_owner == 1) begin
                o_rd = h_rd; o_wr = h_wr; o_row = h_row; o_col = h_col; o_wd = h_wdata;
            end else if (m_owner == 2) begin
                o_rd = e_rd; o_wr = e_wr; o_row = e_row; o_col = e_col; o_wd = e_wdata;
            end
            checks++;
            if ({h_gnt, e_gnt} !== {m_owner == 1, m_owner == 2}) begin
                errors++; bad++;
                $display("FAIL rand_gnt cyc %0d: gnt=%b required %b", cyc, {h_gnt, e_gnt},
                         {m_owner == 1, m_owner == 2});
            end
            checks++;
            if ({mem_wr_en, mem_rd_en, mem_row, mem_col, mem_wdata} !==
                {o_wr, o_rd && !o_wr, o_row, o_col, o_wd}) begin
                errors++; bad++;
                $display("FAIL rand_mem cyc %0d: wr=%b rd=%b row=%0h col=%0h wd=%0h required %b %b %0h %0h %0h",
                         cyc, mem_wr_en, mem_rd_en, mem_row, mem_col, mem_wdata,
                         o_wr, o_rd && !o_wr, o_row, o_col, o_wd);
            end
            checks++;
            if ({h_rvalid, e_rvalid} !== {m_ph, m_pe} || ((m_ph || m_pe) && rdata !== m_pdata)) begin
                errors++; bad++;
                $display("FAIL rand_rd cyc %0d: rvalid=%b rdata=%0h required %b %0h", cyc,
                         {h_rvalid, e_rvalid}, rdata, {m_ph, m_pe}, m_pdata);
            end
            if (bad > 20) begin
                $display("FAIL rand_abort: too many errors");
                break;
            end
            // Advance the model to the state after the coming clock edge.
            if (o_rd && !o_wr) m_pdata = ref_mem[{o_row, o_col}];
            m_ph = o_rd && !o_wr && (m_owner == 1);
            m_pe = o_rd && !o_wr && (m_owner == 2);
            if (o_wr) ref_mem[{o_row, o_col}] = o_wd;
            acc = o_rd || o_wr;
            hit = acc && (m_tenure + 1 >= MB);
            nxt = m_owner;
            if (m_owner == 0) begin
                if (h_req && e_req) nxt = (hp || m_last == 2) ? 1 : 2;
                else if (h_req) nxt = 1;
                else if (e_req) nxt = 2;
            end else begin
                own_req = (m_owner == 1) ? h_req : e_req;
                oth_req = (m_owner == 1) ? e_req : h_req;
                if (!own_req) nxt = oth_req ? 3 - m_owner : 0;
                else if (hit && oth_req && !(hp && m_owner == 1)) nxt = 3 - m_owner;
            end
            if (nxt != m_owner) begin
                m_tenure = 0;
                if (nxt != 0) m_last = nxt;
            end else if (acc) begin
                m_tenure++;
            end
            m_owner = nxt;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_host_write_read();
        test_tie_handover();
        test_burst_limit();
        test_nonowner_write();
        test_rd_wr_same();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_mem_arbiter.md
# matmul_mem_arbiter

Two-requester arbiter sharing one single-port matrix memory (A, B or C bank) between the host loader/unloader and the matrix-multiply control path. It owns the memory read/write enables and row/column address and write-data muxing, and routes read data back to whichever requester issued each read. It bounds each requester's burst length so neither can starve the other. One instance sits in front of each matrix memory bank.

## Interface
- DATA_WIDTH, 8, matrix element width
- ADDR_W, 4, width of row address and of column address
- MAX_BURST, 16, maximum accesses per grant while the other side is requesting (≥2)
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- h_req / e_req  in  1  host / engine request
- h_rd / e_rd  in  1  read command (honoured only while own gnt high)
- h_wr / e_wr  in  1  write command (honoured only while own gnt high)
- h_row, e_row  in  ADDR_W  row address
- h_col, e_col  in  ADDR_W  column address
- h_wdata, e_wdata  in  DATA_WIDTH  write data
- h_gnt / e_gnt  out  1  registered grant
- h_rvalid / e_rvalid  out  1  read data valid for that requester
- rdata  out  DATA_WIDTH  read data, shared, qualified by *_rvalid
- mem_rd_en, mem_wr_en  out  1  memory enables
- mem_row, mem_col  out  ADDR_W  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_rd_en

## Operation
- FSM states: IDLE, OWN_H, OWN_E. h_gnt = (state==OWN_H), e_gnt = (state==OWN_E).
- IDLE: if both request, pick per priority rule (see Configuration); if one requests, grant it; else stay.
- OWN_x: stay while x_req high and burst limit not hit. On x_req low: go to other owner if other req high, else IDLE. On burst limit with other req high: go to other owner.
- Access = owner's rd or wr high in a cycle its gnt is high. Burst counter (clog2(MAX_BURST) bits) clears on every state change, increments per access, saturates; limit hit when the access completing count MAX_BURST occurs.
- If other side not requesting, burst limit ignored; owner keeps grant indefinitely.
- Memory outputs are combinational muxes of owner's signals; in IDLE all enables 0, address/wdata 0.
- rd and wr together: write performed, read dropped (mem_rd_en 0).
- Non-owner commands ignored entirely; no error flagged.
- Read return: registered 1-bit tag of issuing requester + rd flag; x_rvalid asserts cycle after mem_rd_en for issuer even if grant has since moved; rdata = mem_rdata passthrough.
- Round-robin pointer: records last owner; updates on every grant.

## Timing
- Reset: state IDLE, all gnt/rvalid 0, burst count 0, RR pointer = engine (host wins first tie), mem enables 0.
- req→gnt latency from IDLE: 1 cycle (req sampled at edge k, gnt high after edge k).
- Handover: owner drops req at edge k → other gnt high after edge k; no idle gap, never both gnt high.
- Burst limit: MAX_BURSTth access at edge k → grant moves after edge k; that access completes.
- Read latency 1 cycle; back-to-back reads give 1 rvalid/cycle.
- Reset asserted mid-burst: grants drop immediately, pending rvalid is discarded.

## Configuration
- ARB_HOST_PRIO_EN defined: host has fixed priority on IDLE ties and at every handover decision; burst limit still forces engine→host switch, but host is never preempted by the burst limit.
- Undefined: round-robin on ties; burst limit applies to both requesters.

## Test plan
- Reset then h_req=1 alone, write (row 2,col 3,0xA5), read back -> h_gnt after 1 cycle, mem_wr_en with addr 2/3, h_rvalid next cycle after read with rdata 0xA5.
- h_req and e_req rise same edge after reset -> h_gnt first; host drops req -> e_gnt next cycle, no overlap.
- Engine holds req issuing continuous reads, host requests -> after 16th engine access grant moves to host; e_rvalid for 16th read still asserted one cycle later.
- Non-owner writes 0x3C to row 1,col 1 while other owns -> no mem_wr_en for that access; readback shows old value.
- rd and wr same cycle by owner -> mem_wr_en=1, mem_rd_en=0, no rvalid.
- reset_n pulled low mid-burst -> all gnt, rvalid, mem enables 0 immediately; after release IDLE, host wins tie.
